xbar_bridge_req_fifo: RTL and testbench
=======================================

# xbar_bridge_req_fifo

Elastic request buffer placed directly downstream of the two-channel L2 request arbiter in the XBAR bridge. It accepts the arbitrated request stream (address, write-enable, write data, byte enables, ID, aux) with a req/gnt handshake and re-issues it in order to the L2 bank port. The buffer breaks the combinational grant path from the memory port back into the arbiter. It also absorbs short back-pressure bursts without stalling the round-robin rotation.

## Interface
Parameters:
- ID_WIDTH, 20, request ID width
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, write data width
- AUX_WIDTH, 6, aux sideband width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- DEPTH, 2, number of entries; power of two, ≥2
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width

Ports (single clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  1  upstream request valid
- data_add_i  in  ADDR_WIDTH  upstream address
- data_wen_i  in  1  upstream write-enable (1 = read, 0 = write)
- data_wdata_i  in  DATA_WIDTH  upstream write data
- data_be_i  in  BE_WIDTH  upstream byte enables
- data_ID_i  in  ID_WIDTH  upstream ID
- data_aux_i  in  AUX_WIDTH  upstream aux
- data_gnt_o  out  1  upstream grant
- data_req_o  out  1  downstream request valid
- data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o  out  widths as inputs  downstream payload
- data_gnt_i  in  1  downstream grant
- data_cnt_o  out  CNT_WIDTH  current occupancy

## Operation
- Circular buffer of DEPTH entries, each carrying the full payload {add, wen, wdata, be, ID, aux}.
- Write pointer and read pointer are log2(DEPTH) bits and wrap naturally. Occupancy counter is CNT_WIDTH bits, range 0..DEPTH.
- Push: data_req_i & data_gnt_o. Payload is written at the write pointer, and the write pointer increments.
- Pop: data_req_o & data_gnt_i. The read pointer increments.
- data_gnt_o = (cnt != DEPTH). It depends only on registered state and never on data_req_i or data_gnt_i.
- data_req_o = (cnt != 0). The payload outputs are driven from the entry at the read pointer.
- Simultaneous push and pop: both pointers advance and cnt is unchanged. This is legal at any occupancy below DEPTH.
- When full, data_gnt_o = 0, so no push occurs even if a pop happens in the same cycle. The freed slot is granted on the next cycle.
- Ordering is strictly FIFO. The payload is never modified.
- Payload outputs hold their value while data_req_o = 1 and data_gnt_i = 0.
- Upstream sees a grant only when an entry is actually written. The arbiter's round-robin flag therefore toggles once per buffered request.

## Timing
- Reset values:
  - pointers = 0, cnt = 0
  - data_req_o = 0, data_gnt_o = 1, data_cnt_o = 0
  - payload outputs = 0 (storage array is reset to 0)
- Latency without the configuration macro is exactly 1 cycle: a request pushed in cycle N appears on data_req_o in cycle N+1.
- Throughput is 1 request/cycle when not full and downstream grants every cycle.
- Reset asserted mid-operation: all entries are discarded immediately (asynchronous) and outputs return to reset values. No request is replayed.
- data_cnt_o is registered and reflects the state after the last clock edge.

## Configuration
- Macro XBAR_BRIDGE_REQ_FIFO_FALLTHROUGH_EN.
- Defined: when cnt == 0 and data_req_i = 1, the input payload is forwarded combinationally, with data_req_o = 1 and payload outputs taken from the inputs.
  - If data_gnt_i = 1 in that cycle, the request is consumed with zero latency. It is not written and cnt stays 0.
  - If data_gnt_i = 0, it is pushed normally.
  - data_gnt_o remains (cnt != DEPTH).
- Not defined: no combinational path from the data_*_i inputs to the data_*_o outputs. The minimum latency is 1 cycle.

## Test plan
- Reset then idle: data_req_o = 0, data_gnt_o = 1, data_cnt_o = 0 for 10 cycles. After rst_n is released, a single push of add = 0x1C00_0040 / ID = 0x5 appears on the outputs the next cycle.
- Back-pressure fill, DEPTH = 2, data_gnt_i = 0:
  - Push add = 0x10 then add = 0x20; cnt reaches 2 and data_gnt_o = 0.
  - A third request (add = 0x30) stays ungranted.
  - Release data_gnt_i: 0x10 then 0x20 are popped in order, followed by 0x30 after it is granted.
- Streaming: 16 back-to-back pushes with data_gnt_i = 1 constantly.
  - Outputs match inputs delayed 1 cycle (0 cycles with the macro defined).
  - cnt never exceeds 1 (stays 0 with the macro defined).
- Full with simultaneous pop: cnt = 2, data_req_i = 1, data_gnt_i = 1. Exactly one pop, no push, cnt = 1, then push granted the following cycle.
- Pointer wrap: 2·DEPTH+1 pushes interleaved with random data_gnt_i, using wdata = 0xA5A5_0000 + index and be = 0xF. All words are delivered in order with no loss or duplication.
- Reset mid-burst: assert rst_n = 0 with cnt = 2. data_req_o drops immediately, and no stale request appears after rst_n deasserts.

Source files
------------

// File: rtl/xbar_bridge_req_fifo.sv
// xbar_bridge_req_fifo: elastic in-order request buffer between the L2 arbiter and the L2 bank port.
// Optional zero-latency bypass when empty: define XBAR_BRIDGE_REQ_FIFO_FALLTHROUGH_EN.
module xbar_bridge_req_fifo #(
  parameter int ID_WIDTH   = 20,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int AUX_WIDTH  = 6,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  input  logic [AUX_WIDTH-1:0]  data_aux_i,
  output logic                  data_gnt_o,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [ID_WIDTH-1:0]   data_ID_o,
  output logic [AUX_WIDTH-1:0]  data_aux_o,
  input  logic                  data_gnt_i,
  output logic [CNT_WIDTH-1:0]  data_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int W  = ADDR_WIDTH + 1 + DATA_WIDTH + BE_WIDTH + ID_WIDTH + AUX_WIDTH;
  logic [W-1:0]         mem_q [DEPTH];
  logic [W-1:0]         mem_d [DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         din, dout;
  logic                 push, pop;
  assign din = {data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i};
  assign {data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o} = dout;
  // Grant comes only from registered occupancy, which cuts the grant path back into the arbiter.
  assign data_gnt_o = cnt_q != CNT_WIDTH'(DEPTH);
  assign data_cnt_o = cnt_q;
`ifdef XBAR_BRIDGE_REQ_FIFO_FALLTHROUGH_EN
  // When empty, the incoming request is presented downstream directly and is stored only if not taken.
  assign data_req_o = (cnt_q != '0) | data_req_i;
  assign dout       = (cnt_q == '0) ? din : mem_q[rptr_q];
  assign push       = data_req_i & data_gnt_o & ~((cnt_q == '0) & data_gnt_i);
  assign pop        = (cnt_q != '0) & data_gnt_i;
`else
  assign data_req_o = cnt_q != '0;
  assign dout       = mem_q[rptr_q];
  assign push       = data_req_i & data_gnt_o;
  assign pop        = data_req_o & data_gnt_i;
`endif
  // Next state: write the entry at the write pointer, advance pointers, track occupancy.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = din;
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
    cnt_d  = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
  end
  // State registers; storage clears on reset so payload outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_xbar_bridge_req_fifo.sv
// tb_xbar_bridge_req_fifo: directed bench with a queue-based reference model and per-cycle compare.
module tb_xbar_bridge_req_fifo;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [19:0] id;
    logic [5:0]  aux;
  } pl_t;

  logic clk = 0, rst_n;
  logic data_req_i, data_wen_i, data_gnt_o, data_req_o, data_wen_o, data_gnt_i;
  logic [31:0] data_add_i, data_wdata_i, data_add_o, data_wdata_o;
  logic [3:0]  data_be_i, data_be_o;
  logic [19:0] data_ID_i, data_ID_o;
  logic [5:0]  data_aux_i, data_aux_o;
  logic [1:0]  data_cnt_o;
  pl_t in_p, out_p;
  pl_t q[$];
  logic [31:0] log_add[$];
  int checks = 0, fails = 0, maxcnt = 0;
  bit ft_mode = 0;

  assign in_p  = {data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i};
  assign out_p = {data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o};

  always #5 clk = ~clk;

  xbar_bridge_req_fifo dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
    .data_aux_i(data_aux_i), .data_gnt_o(data_gnt_o),
    .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
    .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_ID_o(data_ID_o),
    .data_aux_o(data_aux_o), .data_gnt_i(data_gnt_i), .data_cnt_o(data_cnt_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the buffer is just an ordered queue of accepted requests.
  always @(posedge clk or negedge rst_n) begin
    bit full, ft;
    if (!rst_n) q.delete();
    else begin
      full = q.size() == DEPTH;
      ft = ft_mode && q.size() == 0 && data_req_i;
      if (q.size() > 0 && data_gnt_i) void'(q.pop_front());
      if (data_req_i && !full && !(ft && data_gnt_i)) q.push_back(in_p);
    end
  end

  // Per-cycle compare of every output against the model, and a log of delivered addresses.
  always @(negedge clk) begin
    bit ft;
    ft = ft_mode && q.size() == 0 && data_req_i;
    chk("req_o", data_req_o, q.size() != 0 || ft);
    chk("gnt_o", data_gnt_o, q.size() != DEPTH);
    chk("cnt_o", data_cnt_o, q.size());
    if (data_req_o) chk("payload", out_p, ft ? in_p : q[0]);
    if (data_req_o && data_gnt_i) log_add.push_back(data_add_o);
    if (int'(data_cnt_o) > maxcnt) maxcnt = int'(data_cnt_o);
  end

  initial begin
    int n;
    bit acc;
`ifdef XBAR_BRIDGE_REQ_FIFO_FALLTHROUGH_EN
    ft_mode = 1;
`endif
    rst_n = 0;
    {data_req_i, data_wen_i, data_gnt_i} = '0;
    data_add_i = 0; data_wdata_i = 0; data_be_i = 0; data_ID_i = 0; data_aux_i = 0;
    repeat (3) step();
    chk("rst_req", data_req_o, 1'b0);
    chk("rst_gnt", data_gnt_o, 1'b1);
    chk("rst_cnt", data_cnt_o, 2'd0);
    chk("rst_payload", out_p, '0);
    rst_n = 1;
    repeat (10) step();
    chk("idle_req", data_req_o, 1'b0);
    chk("idle_gnt", data_gnt_o, 1'b1);

    // Single push appears on the outputs one cycle later.
    data_req_i = 1; data_add_i = 32'h1C00_0040; data_ID_i = 20'h5; data_wen_i = 1;
    step();
    data_req_i = 0;
    chk("single_req", data_req_o, 1'b1);
    chk("single_add", data_add_o, 32'h1C00_0040);
    chk("single_id", data_ID_o, 20'h5);
    data_gnt_i = 1;
    step();
    data_gnt_i = 0;
    step();

    // Back-pressure fill, then drain in order; first drain cycle is full with simultaneous pop.
    data_req_i = 1; data_add_i = 32'h10; step();
    data_add_i = 32'h20; step();
    chk("fill_cnt", data_cnt_o, 2'd2);
    chk("fill_gnt", data_gnt_o, 1'b0);
    data_add_i = 32'h30; step();
    chk("third_cnt", data_cnt_o, 2'd2);
    chk("third_gnt", data_gnt_o, 1'b0);
    log_add.delete();
    data_gnt_i = 1; step();
    chk("fullpop_cnt", data_cnt_o, 2'd1);
    chk("fullpop_gnt", data_gnt_o, 1'b1);
    step();
    chk("after_push_cnt", data_cnt_o, 2'd1);
    data_req_i = 0; step();
    data_gnt_i = 0; step();
    chk("drain_n", log_add.size(), 3);
    chk("drain0", log_add[0], 32'h10);
    chk("drain1", log_add[1], 32'h20);
    chk("drain2", log_add[2], 32'h30);

    // Streaming with downstream always granting.
    maxcnt = 0;
    data_gnt_i = 1;
    for (int i = 0; i < 16; i++) begin
      data_req_i = 1; data_add_i = 32'h100 + i; data_wdata_i = i;
      step();
      chk("stream_add", data_add_o, 32'h100 + i);
      chk("stream_req", data_req_o, 1'b1);
    end
    data_req_i = 0; step();
    chk("stream_maxcnt", maxcnt, ft_mode ? 0 : 1);

    // Pointer wrap with random downstream grants.
    log_add.delete();
    for (int i = 0; i < 2*DEPTH+1; i++) begin
      data_req_i = 1; data_add_i = 32'h200 + i; data_wdata_i = 32'hA5A5_0000 + i; data_be_i = 4'hF;
      n = 0;
      do begin
        data_gnt_i = 1'($urandom_range(0, 1));
        acc = data_gnt_o;
        step();
        n++;
      end while (!acc && n < 20);
      if (!acc) chk("wrap_timeout", 0, 1);
    end
    data_req_i = 0; data_gnt_i = 1;
    repeat (4) step();
    chk("wrap_n", log_add.size(), 2*DEPTH+1);
    for (int i = 0; i < 2*DEPTH+1 && i < log_add.size(); i++) chk("wrap_order", log_add[i], 32'h200 + i);

    // Reset mid-burst with a full buffer.
    data_gnt_i = 0; data_req_i = 1; data_add_i = 32'h300;
    step(); data_add_i = 32'h304; step();
    data_req_i = 0;
    chk("pre_rst_cnt", data_cnt_o, 2'd2);
    #2 rst_n = 0;
    #1;
    chk("midrst_req", data_req_o, 1'b0);
    chk("midrst_cnt", data_cnt_o, 2'd0);
    chk("midrst_gnt", data_gnt_o, 1'b1);
    step(); step();
    rst_n = 1;
    data_gnt_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_req", data_req_o, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
